// File: rtl/oric_ram_pkg.sv
// Shared types and defaults for the Oric main-RAM arbiter and its tape FIFO.
package oric_ram_pkg;

   localparam logic [7:0] FILL_DEFAULT = 8'h01;
   localparam int         TAPE_AW_MAX  = 16;

   typedef enum logic {
      ARB_CLEAR,
      ARB_RUN
   } arb_state_t;

   // Addresses narrower than TAPE_AW_MAX are zero-extended into the beat.
   typedef struct packed {
      logic [TAPE_AW_MAX-1:0] addr;
      logic [7:0]             data;
   } tape_beat_t;

endpackage

// File: rtl/oric_ram_tape_fifo.sv
// Small synchronous FIFO buffering tape loader bytes until the RAM port is free.
module oric_ram_tape_fifo
   import oric_ram_pkg::*;
#(
   parameter int LG2 = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push,
   input  logic       pop,
   input  tape_beat_t wr_beat,
   output tape_beat_t rd_beat,
   output logic       empty,
   output logic       full,
   output logic       ready
);

   localparam int DEPTH = 1 << LG2;

   tape_beat_t     mem [DEPTH];
   logic [LG2:0]   wr_ptr;
   logic [LG2:0]   rd_ptr;
   logic [LG2:0]   wr_ptr_nxt;
   logic [LG2:0]   rd_ptr_nxt;
   logic           do_push;
   logic           do_pop;
   logic           full_nxt;

   // Extra pointer MSB distinguishes full from empty when the indices coincide.
   always_comb begin
      empty      = (wr_ptr == rd_ptr);
      full       = (wr_ptr[LG2] != rd_ptr[LG2]) && (wr_ptr[LG2-1:0] == rd_ptr[LG2-1:0]);
      do_push    = push & ~full;
      do_pop     = pop & ~empty;
      wr_ptr_nxt = wr_ptr + (LG2+1)'(do_push);
      rd_ptr_nxt = rd_ptr + (LG2+1)'(do_pop);
      full_nxt   = (wr_ptr_nxt[LG2] != rd_ptr_nxt[LG2]) &&
                   (wr_ptr_nxt[LG2-1:0] == rd_ptr_nxt[LG2-1:0]);
      rd_beat    = mem[rd_ptr[LG2-1:0]];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ready  <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         ready  <= ~full_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[LG2-1:0]] <= wr_beat;
      end
   end

endmodule

// File: rtl/oric_ram_arbiter.sv
// Single-port Oric main RAM owner: post-reset fill, then CPU-priority sharing with
// a FIFO-buffered tape loader that only gets CPU-idle cycles.
module oric_ram_arbiter
   import oric_ram_pkg::*;
#(
   parameter int         AW       = 16,
   parameter logic [7:0] FILL     = FILL_DEFAULT,
   parameter int         FIFO_LG2 = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear_start,
   input  logic          cpu_cs,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_ad,
   input  logic [7:0]    cpu_d,
   output logic [7:0]    cpu_q,
   input  logic          tape_wr,
   input  logic [AW-1:0] tape_addr,
   input  logic [7:0]    tape_dout,
   output logic          tape_ready,
   output logic          tape_idle,
   output logic          clear_done,
   output logic          ram_ce,
   output logic          ram_we,
   output logic [AW-1:0] ram_a,
   output logic [7:0]    ram_d,
   input  logic [7:0]    ram_q
);

   localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [AW:0]   cnt;
   logic [AW:0]   cnt_nxt;
   logic          ce_nxt;
   logic          we_nxt;
   logic [AW-1:0] a_nxt;
   logic [7:0]    d_nxt;
   logic          tape_push;
   logic          tape_pop;
   logic          tape_issued;
   logic          fifo_empty;
   logic          fifo_full;
   tape_beat_t    beat_in;
   tape_beat_t    head;
   logic          unused_head_addr;

   assign cpu_q            = ram_q;
   assign tape_push        = tape_wr & tape_ready & ~fifo_full;
   assign beat_in.addr     = TAPE_AW_MAX'(tape_addr);
   assign beat_in.data     = tape_dout;
   assign tape_idle        = fifo_empty & ~tape_issued;
   assign unused_head_addr = ^head.addr;

   oric_ram_tape_fifo #(
      .LG2 (FIFO_LG2)
   ) u_tape_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (tape_push),
      .pop     (tape_pop),
      .wr_beat (beat_in),
      .rd_beat (head),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .ready   (tape_ready)
   );

   // Port grant: a clear request silences the port for one cycle and restarts the fill;
   // otherwise the fill owns the port, then CPU beats tape, then idle holds address/data.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ce_nxt    = 1'b0;
      we_nxt    = 1'b0;
      a_nxt     = ram_a;
      d_nxt     = ram_d;
      tape_pop  = 1'b0;
      if (clear_start) begin
         state_nxt = ARB_CLEAR;
         cnt_nxt   = '0;
      end else if (state == ARB_CLEAR) begin
         ce_nxt  = 1'b1;
         we_nxt  = 1'b1;
         a_nxt   = cnt[AW-1:0];
         d_nxt   = FILL;
         cnt_nxt = cnt + CNT_ONE;
         if (cnt == CNT_LAST) begin
            state_nxt = ARB_RUN;
         end
      end else if (cpu_cs) begin
         ce_nxt = 1'b1;
         we_nxt = cpu_we;
         a_nxt  = cpu_ad;
         d_nxt  = cpu_d;
      end else if (!fifo_empty) begin
         tape_pop = 1'b1;
         ce_nxt   = 1'b1;
         we_nxt   = 1'b1;
         a_nxt    = head.addr[AW-1:0];
         d_nxt    = head.data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ARB_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // clear_done tracks the registered state so it rises with the final fill write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_ce      <= 1'b0;
         ram_we      <= 1'b0;
         ram_a       <= '0;
         ram_d       <= '0;
         clear_done  <= 1'b0;
         tape_issued <= 1'b0;
      end else begin
         ram_ce      <= ce_nxt;
         ram_we      <= we_nxt;
         ram_a       <= a_nxt;
         ram_d       <= d_nxt;
         clear_done  <= (state_nxt == ARB_RUN);
         tape_issued <= tape_pop;
      end
   end

endmodule

// File: tb/tb_oric_ram_arbiter.sv
// Directed self-checking bench for oric_ram_arbiter with AW=8 and a behavioural sync RAM.
module tb_oric_ram_arbiter;

   logic       clk;
   logic       reset_n;
   logic       clear_start;
   logic       cpu_cs;
   logic       cpu_we;
   logic [7:0] cpu_ad;
   logic [7:0] cpu_d;
   logic [7:0] cpu_q;
   logic       tape_wr;
   logic [7:0] tape_addr;
   logic [7:0] tape_dout;
   logic       tape_ready;
   logic       tape_idle;
   logic       clear_done;
   logic       ram_ce;
   logic       ram_we;
   logic [7:0] ram_a;
   logic [7:0] ram_d;
   logic [7:0] ram_q;

   logic [7:0] mem [256];
   int         checks;
   int         errors;

   oric_ram_arbiter #(
      .AW       (8),
      .FILL     (8'h01),
      .FIFO_LG2 (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear_start (clear_start),
      .cpu_cs      (cpu_cs),
      .cpu_we      (cpu_we),
      .cpu_ad      (cpu_ad),
      .cpu_d       (cpu_d),
      .cpu_q       (cpu_q),
      .tape_wr     (tape_wr),
      .tape_addr   (tape_addr),
      .tape_dout   (tape_dout),
      .tape_ready  (tape_ready),
      .tape_idle   (tape_idle),
      .clear_done  (clear_done),
      .ram_ce      (ram_ce),
      .ram_we      (ram_we),
      .ram_a       (ram_a),
      .ram_d       (ram_d),
      .ram_q       (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port RAM: write-or-read per enabled cycle, read data one clk later.
   always @(posedge clk) begin
      if (ram_ce) begin
         if (ram_we) begin
            mem[ram_a] <= ram_d;
         end else begin
            ram_q <= mem[ram_a];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs, then returns at the following negedge for sampling.
   task automatic applyStimulus(input logic cs, input logic we, input logic [7:0] ad,
                                input logic [7:0] d, input logic twr, input logic [7:0] taddr,
                                input logic [7:0] tdata, input logic clr);
      cpu_cs      = cs;
      cpu_we      = we;
      cpu_ad      = ad;
      cpu_d       = d;
      tape_wr     = twr;
      tape_addr   = taddr;
      tape_dout   = tdata;
      clear_start = clr;
      @(negedge clk);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_ram"}, 32'({ram_ce, ram_we, ram_a, ram_d}), 32'(0));
      checkOutput({tag, "_flags"}, 32'({clear_done, tape_ready, tape_idle}), 32'(3'b001));
   endtask

   // Expects 256 fill writes 0..255 of 8'h01, with clear_done rising alongside the last one.
   task automatic checkFill(input string tag, input bit cpu_noise);
      for (int i = 0; i < 256; i++) begin
         if (cpu_noise && i < 200) begin
            applyStimulus(1'b1, 1'b1, 8'hEE, 8'h77, 1'b0, 8'h00, 8'h00, 1'b0);
         end else begin
            idleCycle();
         end
         checkOutput({tag, "_wr"}, 32'({ram_ce, ram_we, ram_a, ram_d}), 32'({2'b11, 8'(i), 8'h01}));
         checkOutput({tag, "_done"}, 32'(clear_done), 32'(i == 255));
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      checks      = 0;
      errors      = 0;
      reset_n     = 1'b0;
      clear_start = 1'b0;
      cpu_cs      = 1'b0;
      cpu_we      = 1'b0;
      cpu_ad      = 8'h00;
      cpu_d       = 8'h00;
      tape_wr     = 1'b0;
      tape_addr   = 8'h00;
      tape_dout   = 8'h00;
      #1;
      checkResetState("reset");
      @(negedge clk);
      @(negedge clk);
      checkResetState("reset_held");
      reset_n = 1'b1;

      // Fill after reset, with CPU writes attempted during most of it.
      checkFill("fill1", 1'b1);
      idleCycle();
      checkOutput("post_fill_idle", 32'({ram_ce, ram_we, clear_done}), 32'(3'b001));
      checkOutput("post_fill_ready", 32'({tape_ready, tape_idle}), 32'(2'b11));
      checkOutput("fill_no_cpu_write", 32'(mem[8'hEE]), 32'(8'h01));

      // CPU write then read with two-clock latency.
      applyStimulus(1'b1, 1'b1, 8'h34, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b0);
      checkOutput("cpu_wr", 32'({ram_ce, ram_we, ram_a, ram_d}), 32'({2'b11, 8'h34, 8'h5A}));
      applyStimulus(1'b1, 1'b0, 8'h34, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      checkOutput("cpu_rd", 32'({ram_ce, ram_we, ram_a}), 32'({2'b10, 8'h34}));
      idleCycle();
      checkOutput("cpu_q", 32'(cpu_q), 32'(8'h5A));
      checkOutput("idle_hold", 32'({ram_ce, ram_we, ram_a}), 32'({2'b00, 8'h34}));

      // Three tape bytes with the CPU idle.
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h50, 8'hA0, 1'b0);
      checkOutput("tape_q0", 32'({ram_ce, tape_idle}), 32'(2'b00));
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h51, 8'hA1, 1'b0);
      checkOutput("tape_w0", 32'({ram_ce, ram_we, ram_a, ram_d}), 32'({2'b11, 8'h50, 8'hA0}));
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h52, 8'hA2, 1'b0);
      checkOutput("tape_w1", 32'({ram_ce, ram_we, ram_a, ram_d}), 32'({2'b11, 8'h51, 8'hA1}));
      idleCycle();
      checkOutput("tape_w2", 32'({ram_ce, ram_we, ram_a, ram_d}), 32'({2'b11, 8'h52, 8'hA2}));
      checkOutput("tape_busy", 32'(tape_idle), 32'(0));
      idleCycle();
      checkOutput("tape_done", 32'({ram_ce, tape_idle}), 32'(2'b01));

      // CPU holds the port for 10 clocks while 6 bytes are offered: only 4 fit.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 8'h34, 8'h00, (i < 6), 8'(8'h60 + i), 8'(8'hB0 + i), 1'b0);
         checkOutput("starve_no_tape", 32'({ram_ce, ram_we}), 32'(2'b10));
         checkOutput("starve_ready", 32'(tape_ready), 32'(i < 3));
      end
      for (int i = 0; i < 4; i++) begin
         idleCycle();
         checkOutput("drain_wr", 32'({ram_ce, ram_we, ram_a, ram_d}),
                     32'({2'b11, 8'(8'h60 + i), 8'(8'hB0 + i)}));
         checkOutput("drain_ready", 32'(tape_ready), 32'(1));
      end
      idleCycle();
      checkOutput("drain_end", 32'({ram_ce, tape_idle}), 32'(2'b01));
      checkOutput("drop_5", 32'(mem[8'h64]), 32'(8'h01));

      // Clear restart with two tape bytes still queued behind the CPU.
      applyStimulus(1'b1, 1'b0, 8'h34, 8'h00, 1'b1, 8'h70, 8'hC0, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h34, 8'h00, 1'b1, 8'h71, 8'hC1, 1'b0);
      checkOutput("queued_no_tape", 32'({ram_we, tape_idle}), 32'(2'b00));
      applyStimulus(1'b1, 1'b0, 8'h34, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
      checkOutput("clr_start", 32'({ram_ce, clear_done}), 32'(2'b00));
      checkFill("fill2", 1'b0);
      idleCycle();
      checkOutput("q_w0", 32'({ram_ce, ram_we, ram_a, ram_d}), 32'({2'b11, 8'h70, 8'hC0}));
      idleCycle();
      checkOutput("q_w1", 32'({ram_ce, ram_we, ram_a, ram_d}), 32'({2'b11, 8'h71, 8'hC1}));
      idleCycle();
      checkOutput("q_end", 32'({ram_ce, tape_idle}), 32'(2'b01));
      checkOutput("img_70", 32'(mem[8'h70]), 32'(8'hC0));
      checkOutput("img_71", 32'(mem[8'h71]), 32'(8'hC1));
      checkOutput("img_34", 32'(mem[8'h34]), 32'(8'h01));
      checkOutput("img_50", 32'(mem[8'h50]), 32'(8'h01));
      applyStimulus(1'b1, 1'b0, 8'h71, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      idleCycle();
      checkOutput("cpu_q_tape", 32'(cpu_q), 32'(8'hC1));

      // Reset asserted mid-clear, away from any clock edge, with a tape byte queued.
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h80, 8'hD0, 1'b0);
      for (int i = 1; i < 20; i++) begin
         idleCycle();
      end
      checkOutput("mid_clear", 32'({ram_ce, ram_we, ram_a}), 32'({2'b11, 8'd19}));
      #2;
      reset_n = 1'b0;
      #1;
      checkResetState("async_reset");
      @(negedge clk);
      checkResetState("async_reset_held");
      reset_n = 1'b1;
      checkFill("fill3", 1'b0);
      idleCycle();
      checkOutput("fifo_lost", 32'({ram_ce, tape_idle}), 32'(2'b01));
      checkOutput("img_80", 32'(mem[8'h80]), 32'(8'h01));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
